// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32 load/store funct3 encodings
//   - state_e: control FSM states
//   - f3_illegal(): funct3 legality check for loads and stores
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// ----------------------------------------------------------------------------
// lsu_rmw_if
// Bundles the request/response handshake and the word-memory bus of lsu_rmw.
//   req_*  : request from the execute stage (valid/ready)
//   rsp_*  : response to the execute stage (valid/ready)
//   mem_*  : word-organised data memory, combinational read, posedge write
// Modports: slave = the LSU itself, master = its environment (core + memory).
// ----------------------------------------------------------------------------
interface lsu_rmw_if #(
    parameter int MEM_AW = 10
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_wren_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_addr_o, mem_wdata_o, mem_wren_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_addr_o, mem_wdata_o, mem_wren_o
    );
endinterface

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational lane handling for a little-endian 32-bit word.
//   rd_word  in  32  word read from memory
//   st_data  in  32  store data (low byte/half used for SB/SH)
//   offset   in  2   byte offset within the word
//   funct3   in  3   access size / signedness
//   ld_data  out 32  extracted and sign/zero-extended load data
//   st_word  out 32  rd_word with the addressed lane(s) replaced by st_data
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h000000, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0000, h};
            F3_W:    res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] d,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] res;
        res = old;
        case (f3)
            F3_B: res[{off, 3'b000} +: 8] = d[7:0];
            F3_H: begin
                if (off[1]) begin
                    res[31:16] = d[15:0];
                end else begin
                    res[15:0] = d[15:0];
                end
            end
            F3_W:    res = d;
            default: res = old;
        endcase
        return res;
    endfunction

    // Lane extraction and merge for the current access.
    always_comb begin
        ld_data = load_extract(rd_word, offset, funct3);
        st_word = store_merge(rd_word, st_data, offset, funct3);
    end

endmodule

// File: rtl/lsu_rmw.sv
// ----------------------------------------------------------------------------
// lsu_rmw
// Load/store unit: turns byte-addressed RV32 loads/stores into 32-bit word
// accesses. Sub-word stores are read-modify-write because the memory only has
// a whole-word write enable. Bad requests answer with rsp_err_o and never
// touch memory.
//   clk_i  in  clock
//   rst_i  in  synchronous active-high reset
//   bus    lsu_rmw_if.slave: req_* handshake, rsp_* handshake, mem_* bus
// Latency (accept cycle = 0): load/SW response in cycle 2, SB/SH in cycle 3,
// rejected request in cycle 1.
// ----------------------------------------------------------------------------
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic      clk_i,
    input  logic      rst_i,
    lsu_rmw_if.slave  bus
);

    state_e             state_r;
    state_e             state_s;
    logic               we_r;
    logic [2:0]         f3_r;
    logic [1:0]         off_r;
    logic [31:0]        wdata_r;
    logic               ready_r;
    logic               rsp_valid_r;
    logic [31:0]        rdata_r;
    logic               err_r;
    logic [MEM_AW-1:0]  mem_addr_r;
    logic [31:0]        mem_wdata_r;   // also holds the merged word for WRITE
    logic               wren_r;

    logic               accept_s;
    logic               req_err_s;
    logic               sw_req_s;
    logic               wren_next_s;
    logic [31:0]        ld_data_s;
    logic [31:0]        st_word_s;

    lsu_align u_align (
        .rd_word (bus.mem_rdata_i),
        .st_data (wdata_r),
        .offset  (off_r),
        .funct3  (f3_r),
        .ld_data (ld_data_s),
        .st_word (st_word_s)
    );

    // Request decode: acceptance and error classification at accept time.
    always_comb begin
        logic misalign;
        logic out_of_range;
        accept_s     = bus.req_valid_i & ready_r;
        misalign     = (((bus.req_funct3_i == F3_H) || (bus.req_funct3_i == F3_HU))
                        && bus.req_addr_i[0])
                     || ((bus.req_funct3_i == F3_W) && (bus.req_addr_i[1:0] != 2'b00));
        out_of_range = |bus.req_addr_i[31:MEM_AW+2];
        req_err_s    = misalign | out_of_range
                     | f3_illegal(bus.req_we_i, bus.req_funct3_i);
        sw_req_s     = bus.req_we_i & (bus.req_funct3_i == F3_W);
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = ACCESS;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r && (f3_r != F3_W)) begin
                    state_s = WRITE;
                end else begin
                    state_s = RESP;
                end
            end
            WRITE: state_s = RESP;
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Write enable for the coming cycle: SW writes in ACCESS, SB/SH in WRITE.
    // ACCESS is only entered from IDLE, so the SW test uses the live request.
    always_comb begin
        if (state_s == WRITE) begin
            wren_next_s = 1'b1;
        end else if (state_s == ACCESS) begin
            wren_next_s = sw_req_s;
        end else begin
            wren_next_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request registers, registered outputs and memory-side registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r        <= 1'b0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            wdata_r     <= 32'h0000_0000;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            wren_r      <= 1'b0;
        end else begin
            ready_r     <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
            wren_r      <= wren_next_s;
            if (accept_s) begin
                we_r    <= bus.req_we_i;
                f3_r    <= bus.req_funct3_i;
                off_r   <= bus.req_addr_i[1:0];
                wdata_r <= bus.req_wdata_i;
                err_r   <= req_err_s;
                rdata_r <= 32'h0000_0000;
                // Rejected requests leave the memory bus untouched.
                if (!req_err_s) begin
                    mem_addr_r <= bus.req_addr_i[MEM_AW+1:2];
                    if (sw_req_s) begin
                        mem_wdata_r <= bus.req_wdata_i;
                    end
                end
            end else if (state_r == ACCESS) begin
                if (!we_r) begin
                    rdata_r <= ld_data_s;
                end else if (f3_r != F3_W) begin
                    mem_wdata_r <= st_word_s;
                end
            end
        end
    end

    assign bus.req_ready_o = ready_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_rdata_o = rdata_r;
    assign bus.rsp_err_o   = err_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    // Reset suppresses any write in flight, so a partial RMW never lands.
    assign bus.mem_wren_o  = wren_r & ~rst_i;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;
    import lsu_pkg::*;

    localparam int MEM_AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_rmw_if #(.MEM_AW(MEM_AW)) bus ();

    lsu_rmw #(.MEM_AW(MEM_AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural word memory, combinational read, posedge write.
    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic              poke_en   = 1'b0;
    logic [MEM_AW-1:0] poke_addr = '0;
    logic [31:0]       poke_data = 32'h0;
    int                cyc         = 0;
    int                wr_count    = 0;
    int                last_wr_cyc = -1;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_wren_o) begin
            mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            wr_count            <= wr_count + 1;
            last_wr_cyc         <= cyc;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
    end

    logic rsp_rdy = 1'b1;
    assign bus.rsp_ready_i = rsp_rdy;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        bit   in_rsp;
        int   first_cyc;
        exp_t e;
        in_rsp    = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp = 1'b0;
            end else if (bus.rsp_valid_o) begin
                if (!in_rsp) begin
                    in_rsp    = 1'b1;
                    first_cyc = cyc;
                end
                if (rsp_rdy) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: rdata 0x%08h err %0b with none expected",
                                 bus.rsp_rdata_o, bus.rsp_err_o);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                        check("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e.err});
                        check("rsp_cycle", first_cyc, e.cyc);
                    end
                    in_rsp = 1'b0;
                end
            end
        end
    end

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = MEM_AW'(a);
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input bit ee,
                         input int lat, input bit push, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wd;
        while (!bus.req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready_o) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready_o 0 expected 1 within 50 cycles");
            bus.req_valid_i = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (push) sb_q.push_back('{er, ee, cyc + lat});
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb_q.size() != 0 || bus.rsp_valid_o) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int acc;
        int w0;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", {31'h0, bus.req_ready_o}, 32'h1);
        check("rst_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        check("rst_err", {31'h0, bus.rsp_err_o}, 32'h0);
        check("rst_rdata", bus.rsp_rdata_o, 32'h0);
        check("rst_wren", {31'h0, bus.mem_wren_o}, 32'h0);
        check("rst_addr", {22'h0, bus.mem_addr_o}, 32'h0);
        check("rst_wdata", bus.mem_wdata_o, 32'h0);
        rst = 1'b0;

        // 1: byte loads, signed and unsigned
        poke(4, 32'h8899AABB);
        issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_H,  32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b1, acc);
        drain();

        // 2: SB read-modify-write, high bits of wdata ignored
        poke(4, 32'h11223344);
        w0 = wr_count;
        issue(1'b1, F3_B, 32'h11, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 1'b1, acc);
        drain();
        check("sb_write_count", wr_count - w0, 32'd1);
        check("sb_write_cycle", last_wr_cyc, acc + 2);
        check("sb_mem", mem[4], 32'h1122A544);

        // 3: SH upper half, then read back several ways
        poke(4, 32'h11223344);
        issue(1'b1, F3_H, 32'h12, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b1, acc);
        drain();
        check("sh_mem", mem[4], 32'hBEEF3344);
        issue(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_HU, 32'h10, 32'h0, 32'h00003344, 1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_W,  32'h10, 32'h0, 32'hBEEF3344, 1'b0, 2, 1'b1, acc);
        drain();

        // 4: rejected requests never write
        w0 = wr_count;
        issue(1'b0, F3_W,   32'h02,   32'h0,        32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, F3_H,   32'h01,   32'h12345678, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, F3_W,   32'h1000, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b1, F3_BU,  32'h10,   32'h000000FF, 32'h0, 1'b1, 1, 1'b1, acc);
        issue(1'b0, F3_HU,  32'h13,   32'h0,        32'h0, 1'b1, 1, 1'b1, acc);
        drain();
        check("err_no_write", wr_count - w0, 32'd0);
        check("err_mem_intact", mem[4], 32'hBEEF3344);

        // Boundary: last word of memory
        issue(1'b1, F3_W, 32'hFFC, 32'h5A5AC3C3, 32'h0,        1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_W, 32'hFFC, 32'h0,        32'h5A5AC3C3, 1'b0, 2, 1'b1, acc);
        drain();

        // 5: reset during the WRITE cycle of an SB
        poke(4, 32'h11223344);
        w0 = wr_count;
        issue(1'b1, F3_B, 32'h12, 32'h000000EE, 32'h0, 1'b0, 3, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", {31'h0, bus.req_ready_o}, 32'h1);
        check("rst_mid_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
        check("rst_mid_no_write", wr_count - w0, 32'd0);
        check("rst_mid_mem", mem[4], 32'h11223344);

        // 6: response back-pressure
        poke(5, 32'hCAFEF00D);
        rsp_rdy = 1'b0;
        issue(1'b0, F3_W, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
            check("bp_rdata", bus.rsp_rdata_o, 32'hCAFEF00D);
            check("bp_ready", {31'h0, bus.req_ready_o}, 32'h0);
        end
        @(posedge clk);
        #1 rsp_rdy = 1'b1;
        drain();

        // Back-to-back store then load to the same address
        issue(1'b1, F3_W, 32'h18, 32'h12345678, 32'h0,        1'b0, 2, 1'b1, acc);
        issue(1'b0, F3_W, 32'h18, 32'h0,        32'h12345678, 1'b0, 2, 1'b1, acc);
        issue(1'b1, F3_B, 32'h1B, 32'h00000080, 32'h0,        1'b0, 3, 1'b1, acc);
        issue(1'b0, F3_W, 32'h18, 32'h0,        32'h80345678, 1'b0, 2, 1'b1, acc);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
